// File: rtl/cnn_conv_seq.sv
// 3x3 valid-convolution sequencer: fetches nine pixels per output window over an
// OBI-style manager port, accumulates against the kernel, then writes one word per window.
module cnn_conv_seq #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   input_base_i,
  input  logic [ADDR_WIDTH-1:0]   output_base_i,
  input  logic [9*DATA_WIDTH-1:0] weights_i,
  input  logic [3:0]              shift_i,
  input  logic                    relu_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int ACC_W = 2 * DATA_WIDTH + 4;
  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic [2:0]                    state_reg, state_next;
  logic [RW-1:0]                 orow_reg, orow_next;
  logic [CW-1:0]                 ocol_reg, ocol_next;
  logic [1:0]                    kr_reg, kr_next, kc_reg, kc_next;
  logic [3:0]                    k_reg, k_next;
  logic signed [ACC_W-1:0]       acc_reg, acc_next;
  logic [ADDR_WIDTH-1:0]         in_base_reg, out_base_reg;
  logic [9*DATA_WIDTH-1:0]       weights_reg;
  logic [3:0]                    shift_reg;
  logic                          relu_reg;

  logic signed [DATA_WIDTH-1:0]   tap_w [9];
  logic signed [DATA_WIDTH-1:0]   pixel;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        shifted;
  logic signed [DATA_WIDTH-1:0]   result;
  logic [ADDR_WIDTH-1:0]          pix_idx, out_idx, rd_addr, wr_addr;
  logic                           last_out;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      assign tap_w[gi] = weights_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign pixel = mem_rdata_i[DATA_WIDTH-1:0];
  assign prod  = pixel * tap_w[k_reg];

  assign pix_idx = (ADDR_WIDTH'(orow_reg) + ADDR_WIDTH'(kr_reg)) * ADDR_WIDTH'(IMG_W)
                 + ADDR_WIDTH'(ocol_reg) + ADDR_WIDTH'(kc_reg);
  assign out_idx = ADDR_WIDTH'(orow_reg) * ADDR_WIDTH'(IMG_W - 2) + ADDR_WIDTH'(ocol_reg);
  assign rd_addr = in_base_reg + {pix_idx[ADDR_WIDTH-3:0], 2'b00};
  assign wr_addr = out_base_reg + {out_idx[ADDR_WIDTH-3:0], 2'b00};

  assign last_out = (orow_reg == RW'(IMG_H - 3)) && (ocol_reg == CW'(IMG_W - 3));

  // Post-processing works straight off the held accumulator, so wdata is stable during WR_REQ.
  assign shifted = acc_reg >>> shift_reg;
  always_comb begin
    if (shifted > SAT_HI) begin
      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < SAT_LO) begin
      result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      result = shifted[DATA_WIDTH-1:0];
    end
    if (relu_reg && result[DATA_WIDTH-1]) begin
      result = '0;
    end
  end

  assign busy_o      = (state_reg != S_IDLE);
  assign done_o      = (state_reg == S_DONE);
  assign mem_req_o   = (state_reg == S_RD_REQ) || (state_reg == S_WR_REQ);
  assign mem_we_o    = (state_reg == S_WR_REQ);
  assign mem_addr_o  = (state_reg == S_WR_REQ) ? wr_addr :
                       (state_reg == S_RD_REQ) ? rd_addr : '0;
  assign mem_wdata_o = mem_we_o ? {{(32-DATA_WIDTH){result[DATA_WIDTH-1]}}, result} : '0;

  always_comb begin
    state_next = state_reg;
    orow_next  = orow_reg;
    ocol_next  = ocol_reg;
    kr_next    = kr_reg;
    kc_next    = kc_reg;
    k_next     = k_reg;
    acc_next   = acc_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          state_next = S_RD_REQ;
          orow_next  = '0;
          ocol_next  = '0;
          kr_next    = '0;
          kc_next    = '0;
          k_next     = '0;
          acc_next   = '0;
        end
      end
      S_RD_REQ: if (mem_gnt_i) state_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_rvalid_i) begin
          acc_next = acc_reg + ACC_W'(prod);
          if (k_reg == 4'd8) begin
            state_next = S_WR_REQ;
          end else begin
            state_next = S_RD_REQ;
            k_next     = k_reg + 4'd1;
            if (kc_reg == 2'd2) begin
              kc_next = '0;
              kr_next = kr_reg + 2'd1;
            end else begin
              kc_next = kc_reg + 2'd1;
            end
          end
        end
      end
      S_WR_REQ: if (mem_gnt_i) state_next = S_WR_WAIT;
      S_WR_WAIT: begin
        if (mem_rvalid_i) begin
          acc_next = '0;
          k_next   = '0;
          kr_next  = '0;
          kc_next  = '0;
          if (last_out) begin
            state_next = S_DONE;
          end else begin
            state_next = S_RD_REQ;
            if (ocol_reg == CW'(IMG_W - 3)) begin
              ocol_next = '0;
              orow_next = orow_reg + RW'(1);
            end else begin
              ocol_next = ocol_reg + CW'(1);
            end
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= S_IDLE;
      orow_reg     <= '0;
      ocol_reg     <= '0;
      kr_reg       <= '0;
      kc_reg       <= '0;
      k_reg        <= '0;
      acc_reg      <= '0;
      in_base_reg  <= '0;
      out_base_reg <= '0;
      weights_reg  <= '0;
      shift_reg    <= '0;
      relu_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      orow_reg  <= orow_next;
      ocol_reg  <= ocol_next;
      kr_reg    <= kr_next;
      kc_reg    <= kc_next;
      k_reg     <= k_next;
      acc_reg   <= acc_next;
      if (state_reg == S_IDLE && start_i) begin
        in_base_reg  <= input_base_i;
        out_base_reg <= output_base_i;
        weights_reg  <= weights_i;
        shift_reg    <= shift_i;
        relu_reg     <= relu_i;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{mem_rdata_i[31:DATA_WIDTH], pix_idx[ADDR_WIDTH-1:ADDR_WIDTH-2],
                         out_idx[ADDR_WIDTH-1:ADDR_WIDTH-2]};

endmodule

// File: tb/tb_cnn_conv_seq.sv
// Bench for cnn_conv_seq: memory model with optional random stalls, and a plain
// arithmetic convolution reference for every written output.
module tb_cnn_conv_seq;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int OW   = W - 2;
  localparam int NOUT = (W - 2) * (H - 2);

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] input_base_i, output_base_i;
  logic [71:0] weights_i;
  logic [3:0]  shift_i;
  logic        relu_i;
  logic        busy_o, done_o;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        gnt_ok;

  assign mem_gnt = mem_req & gnt_ok;

  cnn_conv_seq #(.IMG_W(W), .IMG_H(H), .ADDR_WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i),
    .input_base_i(input_base_i), .output_base_i(output_base_i),
    .weights_i(weights_i), .shift_i(shift_i), .relu_i(relu_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // Scenario configuration used by both the stimulus and the reference model.
  int          img [64];
  int          wt [9];
  int          cfg_shift;
  bit          cfg_relu;
  logic [31:0] in_base, out_base;

  // Memory model state and observations.
  bit          bp;
  bit          pending, req_seen, hold_valid, pend_we, inject_rv;
  int          rv_wait, gnt_wait;
  logic [31:0] pend_addr, hold_addr, hold_wdata;
  bit          hold_we;
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  int          done_cnt, stable_viol, multi_viol, bad_read;

  always @(posedge clk) begin
    if (rst) begin
      pending    = 1'b0;
      req_seen   = 1'b0;
      hold_valid = 1'b0;
    end else begin
      if (done_o) done_cnt++;
      if (mem_rvalid) pending = 1'b0;
      if (hold_valid && (!mem_req || mem_addr !== hold_addr || mem_we !== hold_we ||
                         mem_wdata !== hold_wdata)) stable_viol++;
      hold_valid = mem_req && !mem_gnt;
      hold_addr  = mem_addr;
      hold_we    = mem_we;
      hold_wdata = mem_wdata;
      if (mem_req && mem_gnt) begin
        if (pending) multi_viol++;
        pending   = 1'b1;
        req_seen  = 1'b0;
        pend_addr = mem_addr;
        pend_we   = mem_we;
        rv_wait   = bp ? int'($urandom_range(0, 3)) : 0;
        if (mem_we) begin
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] off, rd;
    rd = $urandom;
    if (pending && rv_wait == 0) begin
      mem_rvalid = 1'b1;
      if (!pend_we) begin
        off = pend_addr - in_base;
        if (off[1:0] != 2'b00 || off >= 32'd256) bad_read++;
        else rd[7:0] = img[off >> 2][7:0];
      end
    end else begin
      mem_rvalid = inject_rv;
      if (pending) rv_wait--;
    end
    mem_rdata = rd;
    if (mem_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        gnt_wait = bp ? int'($urandom_range(0, 3)) : 0;
      end
      if (gnt_wait == 0) gnt_ok = 1'b1;
      else begin
        gnt_ok = 1'b0;
        gnt_wait--;
      end
    end else begin
      gnt_ok = 1'b0;
    end
  end

  // Reference: direct 3x3 sum, arithmetic shift, clamp, optional ReLU.
  function automatic int expect_out(int orow, int ocol);
    int acc = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        acc += img[(orow + kr) * W + ocol + kc] * wt[kr * 3 + kc];
    acc = acc >>> cfg_shift;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    if (cfg_relu && acc < 0) acc = 0;
    return acc;
  endfunction

  task automatic run_job(input bit bp_en, input bit extra_starts, output int lat);
    bp = bp_en;
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    for (int k = 0; k < 9; k++) weights_i[8*k +: 8] = wt[k][7:0];
    input_base_i  = in_base;
    output_base_i = out_base;
    shift_i       = cfg_shift[3:0];
    relu_i        = cfg_relu;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    // Configuration must already be latched; scramble it for the rest of the run.
    weights_i     = {8'($urandom), 32'($urandom), 32'($urandom)};
    input_base_i  = $urandom;
    output_base_i = $urandom;
    shift_i       = 4'($urandom);
    relu_i        = ~relu_i;
    lat = 1;
    while (!done_o && lat < 20000) begin
      start_i = extra_starts && (lat % 37 == 5);
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    assertions++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    assertions++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done_o); end
    assertions++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    assertions++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    assertions++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    assertions++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_identity();
    int lat;
    for (int i = 0; i < 64; i++) img[i] = i;
    for (int k = 0; k < 9; k++) wt[k] = (k == 4) ? 1 : 0;
    cfg_shift = 0; cfg_relu = 1'b0; in_base = 32'h0000_1000; out_base = 32'h0000_2000;
    run_job(1'b0, 1'b0, lat);
    assertions++; if (lat !== 1 + 20 * NOUT) begin failures++; $display("FAIL identity_latency: got %0d expected %0d", lat, 1 + 20 * NOUT); end
    assertions++; if (done_cnt !== 1) begin failures++; $display("FAIL identity_done_count: got %0d expected 1", done_cnt); end
    assertions++; if (wr_data_q.size() !== NOUT) begin failures++; $display("FAIL identity_writes: got %0d expected %0d", wr_data_q.size(), NOUT); end
    if (wr_data_q.size() == NOUT) begin
      assertions++; if (wr_data_q[0] !== 32'd9) begin failures++; $display("FAIL identity_out0: got %0d expected 9", wr_data_q[0]); end
      assertions++; if (wr_data_q[NOUT-1] !== 32'd54) begin failures++; $display("FAIL identity_out35: got %0d expected 54", wr_data_q[NOUT-1]); end
    end
    for (int i = 0; i < wr_data_q.size() && i < NOUT; i++) begin
      assertions++; if (wr_addr_q[i] !== out_base + 32'(4 * i)) begin failures++; $display("FAIL identity_addr[%0d]: got %h expected %h", i, wr_addr_q[i], out_base + 32'(4 * i)); end
      assertions++; if (wr_data_q[i] !== 32'(expect_out(i / OW, i % OW))) begin failures++; $display("FAIL identity_data[%0d]: got %h expected %h", i, wr_data_q[i], 32'(expect_out(i / OW, i % OW))); end
    end
    $display("test_identity done: %0d writes, latency %0d", wr_data_q.size(), lat);
  endtask

  task automatic test_saturation();
    int lat;
    logic [31:0] req_val;
    for (int i = 0; i < 64; i++) img[i] = 127;
    for (int k = 0; k < 9; k++) wt[k] = 1;
    cfg_relu = 1'b0; in_base = 32'h0001_0000; out_base = 32'h0002_0000;
    for (int s = 0; s <= 4; s += 4) begin
      cfg_shift = s;
      req_val = (s == 0) ? 32'd127 : 32'd71;
      run_job(1'b0, 1'b0, lat);
      assertions++; if (wr_data_q.size() !== NOUT) begin failures++; $display("FAIL sat_writes(shift %0d): got %0d expected %0d", s, wr_data_q.size(), NOUT); end
      for (int i = 0; i < wr_data_q.size() && i < NOUT; i++) begin
        assertions++; if (wr_data_q[i] !== req_val) begin failures++; $display("FAIL sat_data(shift %0d)[%0d]: got %h expected %h", s, i, wr_data_q[i], req_val); end
      end
      $display("test_saturation shift %0d done: %0d writes", s, wr_data_q.size());
    end
  endtask

  task automatic test_relu();
    int lat;
    logic [31:0] req_val;
    for (int i = 0; i < 64; i++) img[i] = -128;
    for (int k = 0; k < 9; k++) wt[k] = 127;
    cfg_shift = 0; in_base = 32'h0000_0400; out_base = 32'h0000_0800;
    for (int r = 0; r < 2; r++) begin
      cfg_relu = r[0];
      req_val = r[0] ? 32'h0 : 32'hFFFF_FF80;
      run_job(1'b0, 1'b0, lat);
      assertions++; if (wr_data_q.size() !== NOUT) begin failures++; $display("FAIL relu_writes(relu %0d): got %0d expected %0d", r, wr_data_q.size(), NOUT); end
      for (int i = 0; i < wr_data_q.size() && i < NOUT; i++) begin
        assertions++; if (wr_data_q[i] !== req_val) begin failures++; $display("FAIL relu_data(relu %0d)[%0d]: got %h expected %h", r, i, wr_data_q[i], req_val); end
      end
      $display("test_relu relu %0d done: %0d writes", r, wr_data_q.size());
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] zw[$];
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 64; i++) img[i] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < 9; k++) wt[k] = int'($urandom_range(0, 255)) - 128;
      cfg_shift = $urandom_range(0, 9); cfg_relu = 1'($urandom);
      in_base = $urandom & 32'hFFFF_FFFC; out_base = $urandom & 32'hFFFF_FFFC;
      stable_viol = 0; multi_viol = 0; bad_read = 0;
      run_job(1'b0, 1'b0, lat);
      zw = wr_data_q;
      run_job(1'b1, 1'b0, lat);
      assertions++; if (wr_data_q.size() !== NOUT) begin failures++; $display("FAIL bp_writes: got %0d expected %0d", wr_data_q.size(), NOUT); end
      for (int i = 0; i < wr_data_q.size() && i < NOUT; i++) begin
        assertions++; if (wr_addr_q[i] !== out_base + 32'(4 * i)) begin failures++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, wr_addr_q[i], out_base + 32'(4 * i)); end
        assertions++; if (wr_data_q[i] !== 32'(expect_out(i / OW, i % OW))) begin failures++; $display("FAIL bp_data[%0d]: got %h expected %h", i, wr_data_q[i], 32'(expect_out(i / OW, i % OW))); end
        if (i < zw.size()) begin
          assertions++; if (zw[i] !== 32'(expect_out(i / OW, i % OW))) begin failures++; $display("FAIL zero_wait_data[%0d]: got %h expected %h", i, zw[i], 32'(expect_out(i / OW, i % OW))); end
        end
      end
      assertions++; if (stable_viol !== 0) begin failures++; $display("FAIL bp_stability: got %0d violations expected 0", stable_viol); end
      assertions++; if (multi_viol !== 0) begin failures++; $display("FAIL bp_outstanding: got %0d violations expected 0", multi_viol); end
      assertions++; if (bad_read !== 0) begin failures++; $display("FAIL bp_read_addr: got %0d bad reads expected 0", bad_read); end
      $display("test_backpressure iter %0d done: %0d writes, latency %0d", it, wr_data_q.size(), lat);
    end
  endtask

  task automatic test_control();
    int lat, cyc, req_seen_cnt, partial;
    for (int i = 0; i < 64; i++) img[i] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < 9; k++) wt[k] = int'($urandom_range(0, 255)) - 128;
    cfg_shift = 6; cfg_relu = 1'b0; in_base = 32'h0000_3000; out_base = 32'h0000_5000;
    run_job(1'b0, 1'b1, lat);
    assertions++; if (lat !== 1 + 20 * NOUT) begin failures++; $display("FAIL ctrl_latency: got %0d expected %0d", lat, 1 + 20 * NOUT); end
    repeat (5) @(negedge clk);
    assertions++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ctrl_busy_after: got %b expected 0", busy_o); end
    assertions++; if (done_cnt !== 1) begin failures++; $display("FAIL ctrl_done_count: got %0d expected 1", done_cnt); end
    assertions++; if (wr_data_q.size() !== NOUT) begin failures++; $display("FAIL ctrl_writes: got %0d expected %0d", wr_data_q.size(), NOUT); end
    $display("test_control extra-start run done: %0d writes, %0d done pulses", wr_data_q.size(), done_cnt);

    // Abort a run partway through output 5.
    wr_addr_q.delete(); wr_data_q.delete(); bp = 1'b0;
    for (int k = 0; k < 9; k++) weights_i[8*k +: 8] = wt[k][7:0];
    input_base_i = in_base; output_base_i = out_base; shift_i = cfg_shift[3:0]; relu_i = cfg_relu;
    @(negedge clk); start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    cyc = 0;
    while (wr_data_q.size() < 5 && cyc < 2000) begin @(negedge clk); cyc++; end
    assertions++; if (wr_data_q.size() !== 5) begin failures++; $display("FAIL ctrl_reach_out5: got %0d writes expected 5", wr_data_q.size()); end
    repeat ($urandom_range(3, 15)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    assertions++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ctrl_rst_req: got %b expected 0", mem_req); end
    assertions++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ctrl_rst_busy: got %b expected 0", busy_o); end
    partial = wr_data_q.size();
    inject_rv = 1'b1;
    @(negedge clk);
    inject_rv = 1'b0;
    req_seen_cnt = 0;
    repeat (10) begin @(negedge clk); if (mem_req || busy_o) req_seen_cnt++; end
    assertions++; if (req_seen_cnt !== 0) begin failures++; $display("FAIL ctrl_quiet_after_rst: got %0d active cycles expected 0", req_seen_cnt); end
    assertions++; if (wr_data_q.size() !== partial) begin failures++; $display("FAIL ctrl_no_writes_after_rst: got %0d expected %0d", wr_data_q.size(), partial); end

    run_job(1'b0, 1'b0, lat);
    assertions++; if (done_cnt !== 1) begin failures++; $display("FAIL ctrl_fresh_done: got %0d expected 1", done_cnt); end
    assertions++; if (wr_data_q.size() !== NOUT) begin failures++; $display("FAIL ctrl_fresh_writes: got %0d expected %0d", wr_data_q.size(), NOUT); end
    for (int i = 0; i < wr_data_q.size() && i < NOUT; i++) begin
      assertions++; if (wr_addr_q[i] !== out_base + 32'(4 * i)) begin failures++; $display("FAIL ctrl_fresh_addr[%0d]: got %h expected %h", i, wr_addr_q[i], out_base + 32'(4 * i)); end
      assertions++; if (wr_data_q[i] !== 32'(expect_out(i / OW, i % OW))) begin failures++; $display("FAIL ctrl_fresh_data[%0d]: got %h expected %h", i, wr_data_q[i], 32'(expect_out(i / OW, i % OW))); end
    end
    $display("test_control reset/restart done: %0d partial writes, %0d fresh writes", partial, wr_data_q.size());
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; inject_rv = 1'b0; bp = 1'b0;
    input_base_i = '0; output_base_i = '0; weights_i = '0; shift_i = '0; relu_i = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; gnt_ok = 1'b0;
    in_base = '0; out_base = '0; cfg_shift = 0; cfg_relu = 1'b0;
    done_cnt = 0; stable_viol = 0; multi_viol = 0; bad_read = 0;
    test_reset();
    test_identity();
    test_saturation();
    test_relu();
    test_backpressure();
    test_control();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
